cache_fill_fsm: RTL and testbench

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

---
 rtl/cache_fill_fsm.sv | 104 ++++++++++
 tb/tb_cache_fill_fsm.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
// Cache miss block-fill controller: streams one read request per cycle to a multicycle memory
// and writes returned words into the data array, then the tag. CACHE_FILL_STATS_EN adds fill_count.
module cache_fill_fsm #(
  parameter int unsigned BLOCK_WORDS = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           miss_detected,
  input  logic [15:0]                    miss_address,
  output logic                           fsm_busy,
  output logic                           mem_read_en,
  output logic [15:0]                    memory_address,
  input  logic                           memory_data_valid,
  input  logic [15:0]                    memory_data,
  output logic                           write_data_array,
  output logic [$clog2(BLOCK_WORDS)-1:0] word_index,
  output logic [15:0]                    fill_data,
`ifdef CACHE_FILL_STATS_EN
  output logic [15:0]                    fill_count,
`endif
  output logic                           write_tag_array
);

  localparam int unsigned IdxW = $clog2(BLOCK_WORDS);
  localparam int unsigned CntW = IdxW + 1;
  // Byte offset within a block spans IdxW+1 bits (16-bit words).
  localparam logic [15:0] OffMask = 16'((32'd1 << (IdxW + 1)) - 32'd1);
  localparam logic [CntW-1:0] ReqLimit = CntW'(BLOCK_WORDS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(BLOCK_WORDS - 1);

  typedef enum logic [0:0] {StIdle, StFill} state_e;

  state_e            state_q;
  logic [15:0]       base_q;
  logic [CntW-1:0]   req_cnt_q;
  logic [IdxW-1:0]   rcv_cnt_q;
  logic              in_fill;
  logic              req_pending;
  logic [CntW-1:0]   req_sel;

  assign in_fill     = (state_q == StFill);
  assign req_pending = (req_cnt_q < ReqLimit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      base_q    <= '0;
      req_cnt_q <= '0;
      rcv_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (miss_detected) begin
            base_q    <= miss_address & ~OffMask;
            req_cnt_q <= '0;
            rcv_cnt_q <= '0;
            state_q   <= StFill;
          end
        end
        StFill: begin
          if (req_pending) begin
            req_cnt_q <= req_cnt_q + 1'b1;
          end
          if (memory_data_valid) begin
            rcv_cnt_q <= rcv_cnt_q + 1'b1;
            if (rcv_cnt_q == LastIdx) begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Once all requests are out, the address holds on the last word of the block.
  always_comb begin
    req_sel = req_pending ? req_cnt_q : CntW'(BLOCK_WORDS - 1);
  end

  assign memory_address   = base_q + (16'(req_sel) << 1);
  assign mem_read_en      = in_fill && req_pending;
  assign fsm_busy         = in_fill || miss_detected;
  // Strobes are held off during reset so an abandoned fill never lands a write.
  assign write_data_array = in_fill && memory_data_valid && !rst;
  assign write_tag_array  = write_data_array && (rcv_cnt_q == LastIdx);
  assign word_index       = rcv_cnt_q;
  assign fill_data        = memory_data;

`ifdef CACHE_FILL_STATS_EN
  logic [15:0] fill_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_count_q <= '0;
    end else if (write_tag_array && (fill_count_q != 16'hFFFF)) begin
      fill_count_q <= fill_count_q + 16'd1;
    end
  end

  assign fill_count = fill_count_q;
`endif

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Randomized self-checking bench for cache_fill_fsm; expectations come from block arithmetic
// and a word-delivery model of the memory.
module tb_cache_fill_fsm;

  localparam int BW = 8;
  localparam int IW = $clog2(BW);

  logic          clk = 1'b0;
  logic          rst;
  logic          miss_detected;
  logic [15:0]   miss_address;
  logic          fsm_busy;
  logic          mem_read_en;
  logic [15:0]   memory_address;
  logic          memory_data_valid;
  logic [15:0]   memory_data;
  logic          write_data_array;
  logic [IW-1:0] word_index;
  logic [15:0]   fill_data;
  logic          write_tag_array;
`ifdef CACHE_FILL_STATS_EN
  logic [15:0]   fill_count;
`endif

  int vectors = 0;
  int miscompares = 0;
  int fills_model = 0;

  cache_fill_fsm #(.BLOCK_WORDS(BW)) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .fsm_busy          (fsm_busy),
    .mem_read_en       (mem_read_en),
    .memory_address    (memory_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .write_data_array  (write_data_array),
    .word_index        (word_index),
    .fill_data         (fill_data),
`ifdef CACHE_FILL_STATS_EN
    .fill_count        (fill_count),
`endif
    .write_tag_array   (write_tag_array)
  );

  always #5 clk = ~clk;

  // Runs one fill. Memory delivers word i no earlier than lat cycles after its request
  // (request i goes out on FILL cycle i+1); bubbles restricts delivery to even cycles.
  // stop_after < BW leaves the fill in flight after that many words.
  task automatic do_fill(input logic [15:0] addr, input int lat, input bit bubbles,
                         input bit inject_miss, input int stop_after);
    logic [15:0] base;
    logic [15:0] exp_addr;
    logic [15:0] data;
    bit          valid;
    bit          done;
    int          delivered;
    int          last_cycle;
    base = addr - (addr % 16'(2 * BW));
    @(negedge clk);
    miss_detected = 1'b1;
    miss_address = addr;
    memory_data_valid = 1'b0;
    #1;
    vectors++;
    if (fsm_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_on_miss: got %b want 1", fsm_busy);
    end
    delivered = 0;
    done = 1'b0;
    last_cycle = 0;
    for (int cycle = 1; cycle <= 3 * BW + lat + 8 && !done; cycle++) begin
      @(negedge clk);
      miss_detected = inject_miss && (cycle == 3);
      miss_address = 16'h5000;
      valid = (delivered < BW) && (cycle >= delivered + 1 + lat) &&
              (!bubbles || (cycle % 2 == 0));
      data = 16'($urandom);
      memory_data_valid = valid;
      memory_data = data;
      #1;
      exp_addr = base + 16'(2 * ((cycle <= BW) ? cycle - 1 : BW - 1));
      vectors++;
      if (fsm_busy !== 1'b1) begin
        miscompares++;
        $display("FAIL busy_fill c%0d: got %b want 1", cycle, fsm_busy);
      end
      vectors++;
      if (mem_read_en !== (cycle <= BW)) begin
        miscompares++;
        $display("FAIL read_en c%0d: got %b want %b", cycle, mem_read_en, cycle <= BW);
      end
      vectors++;
      if (memory_address !== exp_addr) begin
        miscompares++;
        $display("FAIL address c%0d: got %h want %h", cycle, memory_address, exp_addr);
      end
      vectors++;
      if (write_data_array !== valid) begin
        miscompares++;
        $display("FAIL data_wr c%0d: got %b want %b", cycle, write_data_array, valid);
      end
      vectors++;
      if (write_tag_array !== (valid && delivered == BW - 1)) begin
        miscompares++;
        $display("FAIL tag_wr c%0d: got %b want %b", cycle, write_tag_array,
                 valid && delivered == BW - 1);
      end
      if (valid) begin
        vectors++;
        if (word_index !== IW'(delivered)) begin
          miscompares++;
          $display("FAIL word_index c%0d: got %0d want %0d", cycle, word_index, delivered);
        end
        vectors++;
        if (fill_data !== data) begin
          miscompares++;
          $display("FAIL fill_data c%0d: got %h want %h", cycle, fill_data, data);
        end
        delivered++;
        if (delivered == stop_after) begin
          done = 1'b1;
          last_cycle = cycle;
        end
      end
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL fill_timeout: got %0d words want %0d", delivered, stop_after);
    end
    if (stop_after < BW) return;
    if (!bubbles) begin
      vectors++;
      if (last_cycle != BW + lat) begin
        miscompares++;
        $display("FAIL fill_length: got %0d want %0d", last_cycle, BW + lat);
      end
    end
    if (fills_model < 16'hFFFF) fills_model++;
    @(negedge clk);
    miss_detected = 1'b0;
    memory_data_valid = 1'b1;
    #1;
    vectors++;
    if (fsm_busy !== 1'b0 || mem_read_en !== 1'b0 || write_data_array !== 1'b0 ||
        write_tag_array !== 1'b0) begin
      miscompares++;
      $display("FAIL post_fill_idle: got busy=%b rd=%b wr=%b tag=%b want 0000",
               fsm_busy, mem_read_en, write_data_array, write_tag_array);
    end
    vectors++;
    if (memory_address !== base + 16'(2 * (BW - 1))) begin
      miscompares++;
      $display("FAIL addr_hold: got %h want %h", memory_address, base + 16'(2 * (BW - 1)));
    end
    memory_data_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    miss_detected = 1'b1;
    miss_address = 16'hABCD;
    memory_data_valid = 1'b0;
    memory_data = 16'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    miss_detected = 1'b0;
    memory_data_valid = 1'b1;
    #1;
    vectors++;
    if (fsm_busy !== 1'b0 || mem_read_en !== 1'b0 || memory_address !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_state: got busy=%b rd=%b addr=%h want 0 0 0000",
               fsm_busy, mem_read_en, memory_address);
    end
    vectors++;
    if (write_data_array !== 1'b0 || write_tag_array !== 1'b0 || word_index !== '0) begin
      miscompares++;
      $display("FAIL idle_valid_ignored: got wr=%b tag=%b idx=%0d want 0 0 0",
               write_data_array, write_tag_array, word_index);
    end
    fills_model = 0;
`ifdef CACHE_FILL_STATS_EN
    vectors++;
    if (fill_count !== 16'd0) begin
      miscompares++;
      $display("FAIL fill_count_reset: got %0d want 0", fill_count);
    end
`endif
    memory_data_valid = 1'b0;
  endtask

  task automatic test_reset_midfill;
    do_fill(16'h2468, 2, 1'b0, 1'b0, 3);
    @(negedge clk);
    rst = 1'b1;
    miss_detected = 1'b1;
    miss_address = 16'h7777;
    memory_data_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    miss_detected = 1'b0;
    fills_model = 0;
    for (int k = 0; k < 4; k++) begin
      memory_data_valid = 1'b1;
      memory_data = 16'($urandom);
      #1;
      vectors++;
      if (fsm_busy !== 1'b0 || write_data_array !== 1'b0 || write_tag_array !== 1'b0 ||
          mem_read_en !== 1'b0 || memory_address !== 16'h0) begin
        miscompares++;
        $display("FAIL reset_midfill k%0d: got busy=%b wr=%b tag=%b rd=%b addr=%h want all 0",
                 k, fsm_busy, write_data_array, write_tag_array, mem_read_en, memory_address);
      end
      @(negedge clk);
    end
    memory_data_valid = 1'b0;
  endtask

  task automatic test_random_fills;
    for (int n = 0; n < 6; n++) begin
      do_fill(16'($urandom), int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), BW);
    end
  endtask

  task automatic test_fill_count(input string tag);
`ifdef CACHE_FILL_STATS_EN
    @(negedge clk);
    vectors++;
    if (fill_count !== 16'(fills_model)) begin
      miscompares++;
      $display("FAIL fill_count_%s: got %0d want %0d", tag, fill_count, fills_model);
    end
`else
    if (tag.len() == 0) @(negedge clk);
`endif
  endtask

  initial begin
    rst = 1'b1;
    miss_detected = 1'b0;
    miss_address = 16'h0;
    memory_data_valid = 1'b0;
    memory_data = 16'h0;
    test_reset();
    do_fill(16'h1234, 4, 1'b0, 1'b0, BW);  // basic
    do_fill(16'h1234, 4, 1'b0, 1'b1, BW);  // miss mid-fill ignored
    do_fill(16'hFFFA, 3, 1'b0, 1'b0, BW);  // top of address space
    do_fill(16'h0100, 1, 1'b1, 1'b0, BW);  // bubbled returns
    test_random_fills();
    test_fill_count("random");
    test_reset_midfill();
    test_fill_count("after_rst");
    for (int n = 0; n < 3; n++) do_fill(16'($urandom), 2, 1'b0, 1'b0, BW);
    test_fill_count("three");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
